trng_byte_collector: RTL

- Consumer end of the entropy path: takes the raw 1-bit output of the ring oscillator and packs it into bytes for downstream logic.
- Synchronises the asynchronous raw bit and decimates it to a sample rate.
- Applies an optional von Neumann debiaser and a repetition-count health test.
- Presents whole random bytes on a valid/ready interface.
- Sits between the oscillator and the tile's output pins or any future byte sink.

---
 rtl/trng_byte_collector.sv | 135 +++++++++++++
 1 files changed

// File: rtl/trng_byte_collector.sv
// Packs the ring-oscillator raw bit into bytes: 2-flop synchroniser, sample decimation,
// optional von Neumann debiaser, repetition-count health test and a valid/ready byte output.
//
// Debiaser pair state:
//   state      | meaning
//   IDLE       | waiting for the first sample of a pair
//   HAVE_FIRST | first sample stored in pair_first, next strobe completes the pair
module trng_byte_collector #(
   parameter int unsigned SAMPLE_DIV = 4,
   parameter int unsigned REP_LIMIT  = 32,
   parameter bit          DEBIAS     = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       entropy_in,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       health_fail,
   output logic [3:0] fill_level
);

   localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
   localparam logic [7:0] REP_MAX  = 8'(REP_LIMIT);

   typedef enum logic {IDLE, HAVE_FIRST} pair_state_t;

   logic        sync_ff;
   logic        syn;
   logic [7:0]  samp_cnt;
   pair_state_t pair_state;
   logic        pair_first;
   logic [7:0]  run_len;
   logic        last_smp;
   logic [7:0]  shreg;

   logic strobe;
   logic emit_vld;
   logic emit_bit;
   logic fail_now;
   logic take;
   logic out_free;
   logic full;

   assign strobe   = ena && (samp_cnt == DIV_LAST);
   assign fail_now = (run_len >= REP_MAX);
   assign take     = byte_valid && byte_ready;
   assign out_free = !byte_valid || take;
   assign full     = (fill_level == 4'd8);

   always_comb begin
      emit_vld = 1'b0;
      emit_bit = syn;
      if (strobe) begin
         if (DEBIAS) begin
            // (1,0) -> 1 and (0,1) -> 0, so the emitted bit is the first of the pair
            if (pair_state == HAVE_FIRST && syn != pair_first) begin
               emit_vld = 1'b1;
               emit_bit = pair_first;
            end
         end else begin
            emit_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff     <= 1'b0;
         syn         <= 1'b0;
         samp_cnt    <= 8'd0;
         pair_state  <= IDLE;
         pair_first  <= 1'b0;
         run_len     <= 8'd0;
         last_smp    <= 1'b0;
         shreg       <= 8'd0;
         fill_level  <= 4'd0;
         byte_out    <= 8'd0;
         byte_valid  <= 1'b0;
         health_fail <= 1'b0;
      end else begin
         sync_ff <= entropy_in;
         syn     <= sync_ff;

         if (!ena) begin
            samp_cnt   <= 8'd0;
            pair_state <= IDLE;
         end else begin
            samp_cnt <= strobe ? 8'd0 : samp_cnt + 8'd1;
            if (strobe) begin
               if (pair_state == IDLE) begin
                  pair_first <= syn;
                  pair_state <= HAVE_FIRST;
               end else begin
                  pair_state <= IDLE;
               end
            end
         end

         // run_len starts at 0 after reset, so the first sample always lands on 1
         if (strobe) begin
            last_smp <= syn;
            if (syn != last_smp || run_len == 8'd0)
               run_len <= 8'd1;
            else if (run_len != 8'hFF)
               run_len <= run_len + 8'd1;
         end

         if (health_fail || fail_now) begin
            health_fail <= 1'b1;
            byte_valid  <= 1'b0;
         end else if (full) begin
            if (out_free) begin
               byte_out   <= shreg;
               byte_valid <= 1'b1;
               if (emit_vld) begin
                  shreg      <= {shreg[6:0], emit_bit};
                  fill_level <= 4'd1;
               end else begin
                  fill_level <= 4'd0;
               end
            end
         end else begin
            if (take)
               byte_valid <= 1'b0;
            if (emit_vld) begin
               shreg      <= {shreg[6:0], emit_bit};
               fill_level <= fill_level + 4'd1;
            end
         end
      end
   end

endmodule
